cr_ifu_ibuf_pop: RTL
====================

# cr_ifu_ibuf_pop

Read side of the IFU instruction buffer. It scans the halfword entries (valid, 17-bit instruction, access error) from the head pointer and assembles 16-bit or 32-bit instructions. It presents them to decode through a registered valid/ready stage and returns per-entry retire enables to the entries it consumes. It sits between the ibuf entry array and the IU decode stage.

## Interface
- ENTRY_NUM, 8, number of halfword entries; power of two, at least 4.
- PTR_W, 3, read-pointer width; equals log2(ENTRY_NUM).

- cpuclk  in  1  core clock; all state on its rising edge.
- cpurst_b  in  1  reset; synchronous, active-low.
- ibuf_flush  in  1  flush of the whole buffer.
- entry_vld_bus  in  ENTRY_NUM  per-entry valid.
- entry_inst_bus  in  17*ENTRY_NUM  entry i occupies bits [17i+16:17i]; bit 16 is ignored.
- entry_acc_err_bus  in  ENTRY_NUM  per-entry bus access error.
- id_pop_ready  in  1  decode accepts the presented instruction.
- pop_inst_vld  out  1  output register holds an instruction.
- pop_inst  out  32  instruction; bits [31:16] are 0 for a 16-bit instruction.
- pop_inst_16bit  out  1  presented instruction is 16-bit.
- pop_acc_err  out  1  presented instruction carries an access error.
- entry_retire0_en  out  ENTRY_NUM  one-hot pulse: entry retired as the first halfword.
- entry_retire1_en  out  ENTRY_NUM  one-hot pulse: entry retired as the second halfword.
- pop_rptr  out  PTR_W  head pointer.
- pop_empty  out  1  head entry not valid (combinational).

## Operation
- Head H = rptr; second S = (rptr+1) mod ENTRY_NUM.
- Length decode: the head is 32-bit when inst_H[1:0]==2'b11, otherwise 16-bit.
- Head is ready (hd_rdy) when vld_H and any one of the following holds:
  - the head is 16-bit;
  - acc_err_H is 1;
  - vld_S is 1.
- A head with an access error is always popped as a single halfword:
  - pop_inst = {16'b0, inst_H[15:0]}, pop_inst_16bit=1, pop_acc_err=1.
- For a 32-bit instruction:
  - pop_inst = {inst_S[15:0], inst_H[15:0]}.
  - pop_acc_err = acc_err_S.
- Load condition: load = hd_rdy & (~pop_inst_vld | id_pop_ready) & ~ibuf_flush.
- On load:
  - The output register captures the instruction.
  - rptr advances by 1 or 2, modulo ENTRY_NUM.
  - entry_retire0_en[H] pulses.
  - entry_retire1_en[S] pulses if two halfwords were popped.
- Retire pulses are combinational in the load cycle. They are 0 whenever load is 0.
- If id_pop_ready is high and load is 0, pop_inst_vld clears.
- If pop_inst_vld is high and id_pop_ready is low, the output fields are held stable.
- ibuf_flush has priority over everything:
  - rptr←0, pop_inst_vld←0.
  - No retire pulses in that cycle.
- A 32-bit instruction may straddle the wrap boundary (H=ENTRY_NUM-1, S=0). It is handled identically to any other 32-bit instruction.

## Timing
- Reset values (cpurst_b low at an edge): rptr=0, pop_inst_vld=0, pop_inst=0, pop_inst_16bit=0, pop_acc_err=0.
- Retire outputs are 0 whenever load is 0, including while cpurst_b is low.
- Latency: the head becomes ready in cycle N, and pop_inst_vld=1 from cycle N+1.
- Throughput: one instruction per cycle under continuous id_pop_ready.
- Flush with reset deasserted: outputs are empty the cycle after the flush.
- Reset asserted mid-stream discards the output register. No retire is issued.

## Configuration
- CR_IFU_IBUF_RVC_EN defined:
  - 16-bit compressed instructions are decoded as in Operation.
- Not defined:
  - Every instruction is treated as 32-bit. No inst[1:0] check is made, and pop_inst_16bit is tied 0.
  - An access-error head still pops as a single halfword, but with pop_inst_16bit=0.

## Test plan
- Reset with all entries valid holding 0x0001 → pop_inst_vld=0 and rptr=0. After release, pop_inst=0x00000001, pop_inst_16bit=1, retire0[0] pulse, rptr=1.
- Entry0=0x0013 and entry1=0x0000 valid, id_pop_ready=1 → next cycle pop_inst=0x00000013, pop_inst_16bit=0. retire0[0] and retire1[1] pulse together, rptr=2.
- Entry0=0x0013 valid, entry1 invalid for 3 cycles → no load and no retire. When entry1 becomes valid, pop occurs the following cycle.
- pop_inst_vld=1 with id_pop_ready=0 for 4 cycles → pop_inst stable, no retire, rptr unchanged.
- rptr=7, entry7=0x0073 and entry0=0x1000 → pop_inst=0x10000073, retire0[7] and retire1[0], rptr=1.
- Head acc_err=1 with inst 0xFFFF → pop_acc_err=1, pop_inst=0x0000FFFF, single retire0.
- ibuf_flush during a pending load → no retire, rptr=0, pop_inst_vld=0 in the next cycle.

Source files
------------

// File: rtl/cr_ifu_ibuf_pop.sv
// Instruction-buffer read side: assembles 16/32-bit instructions from the head entries
// and presents them to decode. Define CR_IFU_IBUF_RVC_EN to enable 16-bit compressed decode.
module cr_ifu_ibuf_pop #(
    parameter int ENTRY_NUM = 8,
    parameter int PTR_W     = 3
) (
    input  logic                    cpuclk,
    input  logic                    cpurst_b,
    input  logic                    ibuf_flush,
    input  logic [ENTRY_NUM-1:0]    entry_vld_bus,
    input  logic [17*ENTRY_NUM-1:0] entry_inst_bus,
    input  logic [ENTRY_NUM-1:0]    entry_acc_err_bus,
    input  logic                    id_pop_ready,
    output logic                    pop_inst_vld,
    output logic [31:0]             pop_inst,
    output logic                    pop_inst_16bit,
    output logic                    pop_acc_err,
    output logic [ENTRY_NUM-1:0]    entry_retire0_en,
    output logic [ENTRY_NUM-1:0]    entry_retire1_en,
    output logic [PTR_W-1:0]        pop_rptr,
    output logic                    pop_empty
);

`ifdef CR_IFU_IBUF_RVC_EN
    localparam logic RVC_ON = 1'b1;
`else
    localparam logic RVC_ON = 1'b0;
`endif

    logic [15:0]          ent_inst_s [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] unused_bit16_s;

    logic [PTR_W-1:0]     rptr_r;
    logic                 vld_r;
    logic [31:0]          inst_r;
    logic                 inst_16_r;
    logic                 acc_err_r;

    logic [PTR_W-1:0]     sec_ptr_s;
    logic [PTR_W-1:0]     rptr_nxt_s;
    logic                 hd_vld_s;
    logic                 sd_vld_s;
    logic [15:0]          hd_inst_s;
    logic [15:0]          sd_inst_s;
    logic                 hd_err_s;
    logic                 sd_err_s;
    logic                 hd_is32_s;
    logic                 two_s;
    logic                 hd_rdy_s;
    logic                 load_s;
    logic [31:0]          nxt_inst_s;
    logic                 nxt_16_s;
    logic                 nxt_err_s;
    logic [ENTRY_NUM-1:0] retire0_s;
    logic [ENTRY_NUM-1:0] retire1_s;

    // Bit 16 of every entry is carried by the buffer but not used here.
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_unpack
        assign ent_inst_s[gi]     = entry_inst_bus[17*gi +: 16];
        assign unused_bit16_s[gi] = entry_inst_bus[17*gi+16];
    end

    // Head/second entry selection, length decode and load decision.
    always_comb begin
        sec_ptr_s = rptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        hd_vld_s  = entry_vld_bus[rptr_r];
        sd_vld_s  = entry_vld_bus[sec_ptr_s];
        hd_inst_s = ent_inst_s[rptr_r];
        sd_inst_s = ent_inst_s[sec_ptr_s];
        hd_err_s  = entry_acc_err_bus[rptr_r];
        sd_err_s  = entry_acc_err_bus[sec_ptr_s];
`ifdef CR_IFU_IBUF_RVC_EN
        hd_is32_s = (hd_inst_s[1:0] == 2'b11);
`else
        hd_is32_s = 1'b1;
`endif
        // An errored head never consumes a second halfword.
        two_s    = hd_is32_s & ~hd_err_s;
        hd_rdy_s = hd_vld_s & (~two_s | sd_vld_s);
        load_s   = cpurst_b & hd_rdy_s & (~vld_r | id_pop_ready) & ~ibuf_flush;
        if (two_s) begin
            rptr_nxt_s = rptr_r + {{(PTR_W-2){1'b0}}, 2'b10};
        end else begin
            rptr_nxt_s = sec_ptr_s;
        end
    end

    // Output-register capture values for the instruction at the head.
    always_comb begin
        nxt_inst_s = {16'h0000, hd_inst_s};
        nxt_16_s   = 1'b0;
        nxt_err_s  = 1'b0;
        if (hd_err_s) begin
            nxt_inst_s = {16'h0000, hd_inst_s};
            nxt_16_s   = RVC_ON;
            nxt_err_s  = 1'b1;
        end else if (two_s) begin
            nxt_inst_s = {sd_inst_s, hd_inst_s};
            nxt_16_s   = 1'b0;
            nxt_err_s  = sd_err_s;
        end else begin
            nxt_inst_s = {16'h0000, hd_inst_s};
            nxt_16_s   = RVC_ON;
            nxt_err_s  = 1'b0;
        end
    end

    // One-hot retire pulses, only in a load cycle.
    always_comb begin
        retire0_s = {ENTRY_NUM{1'b0}};
        retire1_s = {ENTRY_NUM{1'b0}};
        if (load_s) begin
            retire0_s[rptr_r] = 1'b1;
            if (two_s) begin
                retire1_s[sec_ptr_s] = 1'b1;
            end else begin
                retire1_s = {ENTRY_NUM{1'b0}};
            end
        end else begin
            retire0_s = {ENTRY_NUM{1'b0}};
            retire1_s = {ENTRY_NUM{1'b0}};
        end
    end

    // Head pointer and decode-facing output register; flush beats load.
    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            rptr_r    <= {PTR_W{1'b0}};
            vld_r     <= 1'b0;
            inst_r    <= 32'h0000_0000;
            inst_16_r <= 1'b0;
            acc_err_r <= 1'b0;
        end else if (ibuf_flush) begin
            rptr_r <= {PTR_W{1'b0}};
            vld_r  <= 1'b0;
        end else if (load_s) begin
            rptr_r    <= rptr_nxt_s;
            vld_r     <= 1'b1;
            inst_r    <= nxt_inst_s;
            inst_16_r <= nxt_16_s;
            acc_err_r <= nxt_err_s;
        end else if (id_pop_ready) begin
            vld_r <= 1'b0;
        end
    end

    assign pop_inst_vld     = vld_r;
    assign pop_inst         = inst_r;
    assign pop_inst_16bit   = inst_16_r;
    assign pop_acc_err      = acc_err_r;
    assign pop_rptr         = rptr_r;
    assign pop_empty        = ~hd_vld_s;
    assign entry_retire0_en = retire0_s;
    assign entry_retire1_en = retire1_s;

endmodule
